// File: rtl/seq_scan_arbiter_if.sv
// rtl/seq_scan_arbiter_if.sv - requester, pattern and result signals of the scan arbiter
interface seq_scan_arbiter_if #(
   parameter int P_DATA_W = 8,
   parameter int P_PAT_W  = 4,
   parameter int P_CNT_W  = 4
);
   logic                i_req0_valid;
   logic [P_DATA_W-1:0] i_req0_data;
   logic                o_req0_ready;
   logic                i_req1_valid;
   logic [P_DATA_W-1:0] i_req1_data;
   logic                o_req1_ready;
   logic [P_PAT_W-1:0]  i_pattern;
   logic                o_x;
   logic                o_x_valid;
   logic                o_busy;
   logic                o_done;
   logic                o_done_id;
   logic [P_CNT_W-1:0]  o_match_cnt;

   modport master (
      output i_req0_valid, i_req0_data, i_req1_valid, i_req1_data, i_pattern,
      input  o_req0_ready, o_req1_ready, o_x, o_x_valid, o_busy, o_done, o_done_id, o_match_cnt
   );

   modport slave (
      input  i_req0_valid, i_req0_data, i_req1_valid, i_req1_data, i_pattern,
      output o_req0_ready, o_req1_ready, o_x, o_x_valid, o_busy, o_done, o_done_id, o_match_cnt
   );
endinterface

// File: rtl/seq_scan_arbiter.sv
// rtl/seq_scan_arbiter.sv - round-robin scheduler feeding one serial pattern-count lane
module seq_scan_arbiter #(
   parameter int P_DATA_W = 8,
   parameter int P_PAT_W  = 4,
   parameter int P_CNT_W  = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   seq_scan_arbiter_if.slave    bus
);
   localparam int FILL_W = $clog2(P_PAT_W + 1);
   localparam int IDX_W  = $clog2(P_DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t              state_q;
   logic [P_DATA_W-1:0] sh_q;
   logic [P_PAT_W-2:0]  hist_q;
   logic [FILL_W-1:0]   fill_q;
   logic [IDX_W-1:0]    idx_q;
   logic [P_CNT_W-1:0]  cnt_q;
   logic [P_CNT_W-1:0]  cnt_d;
   logic [P_PAT_W-1:0]  pat_q;
   logic                id_q;
   logic                last_q;
   logic                busy_q;
   logic                x_valid_q;
   logic                done_q;
   logic                done_id_q;
   logic [P_CNT_W-1:0]  match_cnt_q;

   logic                any_valid;
   logic                gnt_id;
   logic                bit_x;
   logic [P_PAT_W-1:0]  window;
   logic                hit;

   // last_q names the most recently served requester; with both valid the other one wins
   assign any_valid = bus.i_req0_valid | bus.i_req1_valid;
   assign gnt_id    = (bus.i_req0_valid & bus.i_req1_valid) ? ~last_q : bus.i_req1_valid;

   assign bit_x  = sh_q[P_DATA_W-1];
   assign window = {hist_q, bit_x};
   assign hit    = (fill_q >= FILL_W'(P_PAT_W - 1)) && (window == pat_q);
   assign cnt_d  = (hit && (cnt_q != '1)) ? cnt_q + P_CNT_W'(1) : cnt_q;

   assign bus.o_req0_ready = (state_q == S_IDLE) & bus.i_req0_valid & ~gnt_id;
   assign bus.o_req1_ready = (state_q == S_IDLE) & bus.i_req1_valid & gnt_id;
   assign bus.o_x          = bit_x;
   assign bus.o_x_valid    = x_valid_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_done       = done_q;
   assign bus.o_done_id    = done_id_q;
   assign bus.o_match_cnt  = match_cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         sh_q        <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         pat_q       <= '0;
         id_q        <= 1'b0;
         last_q      <= 1'b1;
         busy_q      <= 1'b0;
         x_valid_q   <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= 1'b0;
         match_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (any_valid) begin
                  sh_q      <= gnt_id ? bus.i_req1_data : bus.i_req0_data;
                  pat_q     <= bus.i_pattern;
                  id_q      <= gnt_id;
                  hist_q    <= '0;
                  fill_q    <= '0;
                  idx_q     <= '0;
                  cnt_q     <= '0;
                  busy_q    <= 1'b1;
                  x_valid_q <= 1'b1;
                  state_q   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               sh_q   <= sh_q << 1;
               hist_q <= window[P_PAT_W-2:0];
               if (fill_q != FILL_W'(P_PAT_W)) begin
                  fill_q <= fill_q + FILL_W'(1);
               end
               cnt_q <= cnt_d;
               idx_q <= idx_q + IDX_W'(1);
               // cnt_d already includes a match completed by the final bit
               if (idx_q == IDX_W'(P_DATA_W - 1)) begin
                  x_valid_q   <= 1'b0;
                  done_q      <= 1'b1;
                  done_id_q   <= id_q;
                  match_cnt_q <= cnt_d;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               last_q  <= id_q;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_scan_arbiter.sv
// tb/tb_seq_scan_arbiter.sv - randomized and directed check of seq_scan_arbiter against a behavioural model
module tb_seq_scan_arbiter;
   localparam int DW = 8;
   localparam int PW = 4;
   localparam int CW = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] v   = 2'b00;
   logic [7:0] d [2];
   logic [3:0] pat = 4'd0;

   int vectors     = 0;
   int miscompares = 0;

   int  acc_cnt [2];
   int  done_cnt = 0;
   bit  served [$];

   int         m_phase = 0;
   bit         m_last  = 1'b1;
   bit         m_id    = 1'b0;
   logic [7:0] m_data  = 8'd0;
   int         m_exp   = 0;

   always #5 clk = ~clk;

   seq_scan_arbiter_if #(.P_DATA_W(DW), .P_PAT_W(PW), .P_CNT_W(CW)) bus ();

   assign bus.i_req0_valid = v[0];
   assign bus.i_req1_valid = v[1];
   assign bus.i_req0_data  = d[0];
   assign bus.i_req1_data  = d[1];
   assign bus.i_pattern    = pat;

   seq_scan_arbiter #(.P_DATA_W(DW), .P_PAT_W(PW), .P_CNT_W(CW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // counts every window position of the word that equals the pattern, overlaps included
   function automatic int ref_count(input logic [7:0] w, input logic [3:0] p);
      int n = 0;
      for (int i = 0; i <= DW - PW; i++) begin
         if (w[DW-1-i -: PW] == p) n++;
      end
      if (n > (1 << CW) - 1) n = (1 << CW) - 1;
      return n;
   endfunction

   always @(negedge clk) begin
      bit e0;
      bit e1;
      if (rst) begin
         m_phase = 0;
         m_last  = 1'b1;
      end else if (m_phase == 0) begin
         e0 = v[0] && (!v[1] || m_last);
         e1 = v[1] && (!v[0] || !m_last);
         chk("ready0", bus.o_req0_ready, e0);
         chk("ready1", bus.o_req1_ready, e1);
         chk("busy_idle", bus.o_busy, 0);
         chk("done_idle", bus.o_done, 0);
         chk("xvalid_idle", bus.o_x_valid, 0);
         if (e0 || e1) begin
            m_id   = e1;
            m_data = d[m_id];
            m_exp  = ref_count(m_data, pat);
            acc_cnt[m_id] = acc_cnt[m_id] + 1;
            m_phase = 1;
         end
      end else if (m_phase <= DW) begin
         chk("xvalid", bus.o_x_valid, 1);
         chk("x_bit", bus.o_x, m_data[DW-m_phase]);
         chk("ready_shift", {bus.o_req1_ready, bus.o_req0_ready}, 0);
         chk("busy_shift", bus.o_busy, 1);
         chk("done_shift", bus.o_done, 0);
         m_phase++;
      end else begin
         chk("done", bus.o_done, 1);
         chk("done_id", bus.o_done_id, m_id);
         chk("match_cnt", bus.o_match_cnt, m_exp);
         chk("ready_done", {bus.o_req1_ready, bus.o_req0_ready}, 0);
         chk("xvalid_done", bus.o_x_valid, 0);
         m_last = m_id;
         served.push_back(m_id);
         done_cnt++;
         m_phase = 0;
      end
   end

   task automatic start_job(input int id, input logic [7:0] data, input logic [3:0] p);
      int a;
      bit ok = 1'b0;
      @(posedge clk); #1;
      a      = acc_cnt[id];
      pat    = p;
      d[id]  = data;
      v[id]  = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(posedge clk); #1;
         if (acc_cnt[id] != a) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      v[id] = 1'b0;
   endtask

   task automatic wait_done();
      int n = done_cnt;
      bit ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk); #1;
         if (done_cnt != n) ok = 1'b1;
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int b;
      int seen [2];
      int issued [2];
      int got [2];
      bit fin;
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      d[0] = 8'd0; d[1] = 8'd0;

      @(posedge clk); #1;
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_xvalid", bus.o_x_valid, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_done_id", bus.o_done_id, 0);
      chk("rst_cnt", bus.o_match_cnt, 0);
      chk("rst_x", bus.o_x, 0);
      rst = 1'b0;

      start_job(0, 8'b1001_0011, 4'b1001); wait_done();
      chk("t1_cnt", bus.o_match_cnt, 2);
      chk("t1_id", bus.o_done_id, 0);

      start_job(1, 8'hFF, 4'b1111); wait_done();
      chk("t2_cnt_ones", bus.o_match_cnt, 5);
      chk("t2_id", bus.o_done_id, 1);
      start_job(1, 8'hFF, 4'b0000); wait_done();
      chk("t2_cnt_zero", bus.o_match_cnt, 0);

      start_job(0, 8'h04, 4'b1001); wait_done();
      chk("t4_cnt_a", bus.o_match_cnt, 0);
      start_job(0, 8'h80, 4'b1001); wait_done();
      chk("t4_cnt_b", bus.o_match_cnt, 0);
      start_job(0, 8'h09, 4'b1001); wait_done();
      chk("t4_cnt_last", bus.o_match_cnt, 1);

      start_job(0, 8'b1001_0011, 4'b1001);
      @(posedge clk); #1;
      @(posedge clk); #1;
      pat = 4'b0000;
      wait_done();
      chk("t6_cnt", bus.o_match_cnt, 2);

      start_job(0, 8'b1001_0011, 4'b1001);
      b = done_cnt;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("t5_busy", bus.o_busy, 0);
      chk("t5_xvalid", bus.o_x_valid, 0);
      chk("t5_x", bus.o_x, 0);
      chk("t5_done", bus.o_done, 0);
      chk("t5_cnt", bus.o_match_cnt, 0);
      chk("t5_id", bus.o_done_id, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("t5_nodone", done_cnt - b, 0);
      start_job(0, 8'b1001_0011, 4'b1001); wait_done();
      chk("t5_after", bus.o_match_cnt, 2);

      @(posedge clk); #1;
      rst = 1'b1;
      v = 2'b11;
      d[0] = 8'($urandom); d[1] = 8'($urandom);
      pat = 4'($urandom);
      @(posedge clk); #1;
      rst = 1'b0;
      b = served.size();
      seen[0] = acc_cnt[0]; seen[1] = acc_cnt[1];
      issued[0] = 1; issued[1] = 1;
      fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            if (acc_cnt[k] != seen[k]) begin
               seen[k] = acc_cnt[k];
               if (issued[k] < 2) begin
                  d[k] = 8'($urandom);
                  issued[k]++;
               end else begin
                  v[k] = 1'b0;
               end
            end
         end
         if (served.size() >= b + 4) fin = 1'b1;
      end
      chk("t3_jobs", served.size() - b, 4);
      if (served.size() >= b + 4) begin
         for (int j = 0; j < 4; j++) chk("t3_order", served[b+j], j % 2);
      end

      b = served.size();
      seen[0] = acc_cnt[0]; seen[1] = acc_cnt[1];
      issued[0] = 0; issued[1] = 0;
      fin = 1'b0;
      for (int i = 0; i < 800 && !fin; i++) begin
         @(posedge clk); #1;
         pat = 4'($urandom);
         for (int k = 0; k < 2; k++) begin
            if (acc_cnt[k] != seen[k]) begin
               seen[k] = acc_cnt[k];
               if (issued[k] < 12 && $urandom_range(1) == 1) begin
                  d[k] = 8'($urandom);
                  issued[k]++;
               end else begin
                  v[k] = 1'b0;
               end
            end else if (!v[k] && issued[k] < 12 && $urandom_range(3) == 0) begin
               d[k] = 8'($urandom);
               v[k] = 1'b1;
               issued[k]++;
            end
         end
         if (issued[0] == 12 && issued[1] == 12 && v == 2'b00 && served.size() == b + 24) fin = 1'b1;
      end
      got[0] = 0; got[1] = 0;
      for (int j = b; j < served.size(); j++) got[served[j]]++;
      chk("rand_served0", got[0], issued[0]);
      chk("rand_served1", got[1], issued[1]);
      chk("rand_drained", fin, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/seq_scan_arbiter.md
Name: seq_scan_arbiter

Overview:
- Shares one serial pattern-detection lane between two parallel-word requesters.
- Arbitrates round-robin, loads the granted word and shifts it MSB-first onto a serial bit stream.
- Counts overlapping occurrences of a programmable bit pattern within that word, then reports the count with the requester ID.
- Sits in front of the serial sequence-detector datapath and acts as its scheduler and configurator.

Parameters:
P_DATA_W, 8, width of each requester word, bits shifted per job (>= P_PAT_W)
P_PAT_W, 4, width of the detected pattern
P_CNT_W, 4, width of the match counter; must hold P_DATA_W-P_PAT_W+1

Ports:
i_clk  input  1  clock, rising-edge
i_rst  input  1  asynchronous active-high reset
i_req0_valid  input  1  requester 0 has a word
i_req0_data  input  P_DATA_W  requester 0 word
o_req0_ready  output  1  requester 0 word accepted this cycle
i_req1_valid  input  1  requester 1 has a word
i_req1_data  input  P_DATA_W  requester 1 word
o_req1_ready  output  1  requester 1 word accepted this cycle
i_pattern  input  P_PAT_W  pattern to detect; bit [P_PAT_W-1] is the first-received bit
o_x  output  1  current serial bit (MSB of shift register)
o_x_valid  output  1  o_x is meaningful
o_busy  output  1  job in progress (state != IDLE)
o_done  output  1  one-cycle pulse: job complete
o_done_id  output  1  requester ID of completed job
o_match_cnt  output  P_CNT_W  match count of completed job

Behaviour:
- Interface: single clock i_clk; i_rst is asynchronous and active-high and clears every register immediately.
- Reset values: state IDLE; shift/history/fill/bit-index/count registers 0; o_done 0; o_done_id 0; o_match_cnt 0; o_x_valid 0; o_busy 0; round-robin pointer favours requester 0.
- FSM states: IDLE, SHIFT, DONE.

IDLE:
- If neither valid is asserted, stay in IDLE.
- If only one valid is asserted, grant it.
- If both are asserted, grant the requester that was NOT granted most recently.
- o_reqN_ready is combinational: asserted only in IDLE for the granted requester, in the same cycle as its valid.
- On the accept edge:
  - load data into the shift register;
  - latch i_pattern into r_pat;
  - latch the grant ID;
  - clear history, fill counter, bit index and running count;
  - go to SHIFT.
- Requesters must hold valid/data until ready. A valid that drops without ready is simply not served.

SHIFT (exactly P_DATA_W cycles):
- o_x = shift-register MSB; o_x_valid = 1.
- Each edge:
  - shift left;
  - hist <= {hist[P_PAT_W-2:0], o_x};
  - fill saturates at P_PAT_W.
- Match when (fill >= P_PAT_W-1) and {hist[P_PAT_W-2:0], o_x} == r_pat. On a match, count increments, saturating at all-ones.
- Matches overlap: history is never cleared on a match.
- After the P_DATA_W-th bit, go to DONE.

DONE (one cycle):
- o_done = 1; o_done_id = grant ID; o_match_cnt = final count.
- o_done_id and o_match_cnt are registered and hold until the next DONE.
- Update the round-robin pointer to the served ID; return to IDLE.
- No ready is asserted in DONE.

Timing:
- Latency: accept at edge T; bits on o_x during cycles T+1..T+P_DATA_W; o_done high in cycle T+P_DATA_W+1.
- Next accept is possible in the cycle after DONE.

Boundary conditions:
- Matches never span words: history and fill are cleared at every accept.
- i_pattern changes during SHIFT are ignored until the next accept.
- Reset mid-SHIFT or mid-DONE: the job is discarded, no o_done is produced, and the arbiter returns to reset state.
- Counter saturation is reachable only if P_CNT_W is misconfigured; it must still saturate, not wrap.

Test Plan:
1. Reset, pattern 4'b1001, req0 data 8'b1001_0011 -> o_x stream 1,0,0,1,0,0,1,1 over 8 cycles; o_done 9 cycles after accept; o_done_id 0; o_match_cnt 2 (overlap at shared bit 3).
2. Pattern 4'b1111, req1 data 8'hFF -> o_match_cnt 5, o_done_id 1; pattern 4'b0000 with 8'hFF -> 0.
3. Both valids held from reset, continuous words -> grants 0,1,0,1; each ready pulse is exactly one cycle, only in IDLE; no job is lost.
4. Pattern 4'b1001: word 8'h04 then 8'h80 from req0 -> both counts 0 (no cross-word match); word 8'h09 -> count 1, match on final bit.
5. Assert i_rst for 1 cycle after 3 SHIFT bits -> all outputs 0 immediately; no o_done; a subsequent req0 job 8'b1001_0011 completes with count 2.
6. Change i_pattern from 4'b1001 to 4'b0000 mid-SHIFT of 8'b1001_0011 -> o_match_cnt still 2.
